pwm_duty_sequencer: RTL and testbench

Upstream stage for `pulse_width_modulation`: generates the 4-bit `duty_cycle` word that the PWM block consumes, stepping it over time in manual, sawtooth, triangle ("breathing") or full-on patterns. Updates are paced by an internal step timer aligned to whole 16-cycle PWM periods, so the PWM never sees mid-period duty changes. Duty encoding matches the PWM: 4'h1..4'hF = n/16, 4'h0 = 100%.

---
 rtl/pwm_pkg.sv | 36 +++
 rtl/pwm_step_timer.sv | 31 +++
 rtl/pwm_duty_sequencer.sv | 129 ++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty width, period, mode codes and sequencer states.
package pwm_pkg;

  localparam int unsigned DUTY_W     = 4;
  localparam int unsigned PWM_PERIOD = 16;

  localparam logic [1:0] MODE_MANUAL   = 2'b00;
  localparam logic [1:0] MODE_SAW      = 2'b01;
  localparam logic [1:0] MODE_TRIANGLE = 2'b10;
  localparam logic [1:0] MODE_FULL     = 2'b11;

  // 4'h0 is decoded by the PWM as 100% duty
  localparam logic [DUTY_W-1:0] DUTY_FULL = 4'h0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MANUAL,
    S_SAW,
    S_TRI_UP,
    S_TRI_DOWN,
    S_FULL
  } seq_state_e;

  // Run state selected by a mode code; triangle resumes in the current direction
  function automatic seq_state_e mode_state(input logic [1:0] mode, input logic dir);
    seq_state_e st;
    unique case (mode)
      MODE_MANUAL:   st = S_MANUAL;
      MODE_SAW:      st = S_SAW;
      MODE_TRIANGLE: st = dir ? S_TRI_UP : S_TRI_DOWN;
      default:       st = S_FULL;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Step pacing timer: counts 0..STEP_TICKS-1 while enabled, tick marks the last count.
module pwm_step_timer #(
  parameter int unsigned STEP_TICKS = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(STEP_TICKS - 2);

  logic [CNT_W-1:0] count;

  // Counter plus registered tick; tick is high exactly while count sits at its last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (!enable) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
      tick  <= (count == CNT_PRE);
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty-word sequencer feeding pulse_width_modulation: manual, sawtooth, triangle and full-on patterns.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 64,
  parameter int unsigned MIN_DUTY   = 1,
  parameter int unsigned MAX_DUTY   = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic                btn_up,
  input  logic                btn_down,
  output logic [DUTY_W-1:0]   duty_cycle,
  output logic                step_strobe,
  output logic                direction
);

  // Duty steps must land on whole PWM periods; ramp bounds must be a legal nonzero range
  if (STEP_TICKS == 0 || (STEP_TICKS % PWM_PERIOD) != 0) begin : g_bad_step_ticks
    $fatal(1, "pwm_duty_sequencer: STEP_TICKS must be a nonzero multiple of %0d", PWM_PERIOD);
  end
  if (MIN_DUTY < 1 || MIN_DUTY > 14 || MAX_DUTY <= MIN_DUTY || MAX_DUTY > 15) begin : g_bad_range
    $fatal(1, "pwm_duty_sequencer: illegal MIN_DUTY/MAX_DUTY");
  end

  localparam logic [DUTY_W-1:0] MIN_L = DUTY_W'(MIN_DUTY);
  localparam logic [DUTY_W-1:0] MAX_L = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] ONE   = DUTY_W'(1);

  seq_state_e        state, state_n, target;
  logic [DUTY_W-1:0] level, level_n, duty_n;
  logic              dir_n, strobe_n;
  logic              up_pend, dn_pend, up_pend_n, dn_pend_n;
  logic              up_req, dn_req;
  logic              timer_en, tick;

  assign timer_en = enable && (state != S_IDLE);

  pwm_step_timer #(.STEP_TICKS(STEP_TICKS)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (timer_en),
    .tick   (tick)
  );

  // State, level and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      level       <= MIN_L;
      direction   <= 1'b1;
      duty_cycle  <= MIN_L;
      step_strobe <= 1'b0;
      up_pend     <= 1'b0;
      dn_pend     <= 1'b0;
    end else begin
      state       <= state_n;
      level       <= level_n;
      direction   <= dir_n;
      duty_cycle  <= duty_n;
      step_strobe <= strobe_n;
      up_pend     <= up_pend_n;
      dn_pend     <= dn_pend_n;
    end
  end

  // Next-state: mode is sampled only at tick, where the new mode's step is applied immediately
  always_comb begin
    state_n   = state;
    target    = state;
    level_n   = level;
    dir_n     = direction;
    duty_n    = duty_cycle;
    strobe_n  = 1'b0;
    up_pend_n = 1'b0;
    dn_pend_n = 1'b0;
    up_req    = up_pend | btn_up;
    dn_req    = dn_pend | btn_down;

    if (!enable) begin
      state_n = S_IDLE;
    end else if (state == S_IDLE) begin
      state_n = mode_state(mode, direction);
    end else if (!tick) begin
      if (state == S_MANUAL) begin
        up_pend_n = up_req;
        dn_pend_n = dn_req;
      end
    end else begin
      target  = mode_state(mode, direction);
      state_n = target;
      unique case (target)
        S_MANUAL: begin
          if (up_req && !dn_req && level < MAX_L) begin
            level_n = level + ONE;
          end else if (dn_req && !up_req && level > MIN_L) begin
            level_n = level - ONE;
          end
        end
        S_SAW: begin
          level_n = (level >= MAX_L) ? MIN_L : level + ONE;
          dir_n   = 1'b1;
        end
        S_TRI_UP, S_TRI_DOWN: begin
          if (target == S_TRI_UP) begin
            level_n = (level >= MAX_L) ? level - ONE : level + ONE;
          end else begin
            level_n = (level <= MIN_L) ? level + ONE : level - ONE;
          end
          // reverse on reaching an endpoint so it is held for exactly one interval
          if (level_n == MAX_L) begin
            dir_n = 1'b0;
          end else if (level_n == MIN_L) begin
            dir_n = 1'b1;
          end else begin
            dir_n = (level_n > level);
          end
          state_n = dir_n ? S_TRI_UP : S_TRI_DOWN;
        end
        default: ;
      endcase
      duty_n   = (target == S_FULL) ? DUTY_FULL : level_n;
      strobe_n = (duty_n != duty_cycle);
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer with STEP_TICKS=16.
module tb_pwm_duty_sequencer;

  localparam int STEP = 16;
  localparam int LO   = 1;
  localparam int HI   = 15;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] duty_cycle;
  logic       step_strobe;
  logic       direction;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_duty_sequencer #(.STEP_TICKS(STEP), .MIN_DUTY(LO), .MAX_DUTY(HI)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .duty_cycle  (duty_cycle),
    .step_strobe (step_strobe),
    .direction   (direction)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a step happens every STEP enabled run cycles,
  // and the step rule is chosen by the mode seen on that cycle.
  int m_level, m_dir, m_duty, m_strobe, m_run, m_cnt, m_cur, m_pu, m_pd;

  task automatic model_reset();
    m_level = LO; m_dir = 1; m_duty = LO; m_strobe = 0;
    m_run = 0; m_cnt = 0; m_cur = 0; m_pu = 0; m_pd = 0;
  endtask

  task automatic model_step();
    int up, dn;
    m_strobe = 0;
    if (!enable) begin
      m_run = 0; m_cnt = 0; m_pu = 0; m_pd = 0;
    end else if (m_run == 0) begin
      m_run = 1; m_cnt = 0; m_cur = int'(mode); m_pu = 0; m_pd = 0;
    end else begin
      m_cnt++;
      if (m_cnt < STEP) begin
        if (m_cur == 0) begin
          m_pu = m_pu | int'(btn_up);
          m_pd = m_pd | int'(btn_down);
        end else begin
          m_pu = 0; m_pd = 0;
        end
      end else begin
        m_cnt = 0;
        m_cur = int'(mode);
        up = m_pu | int'(btn_up);
        dn = m_pd | int'(btn_down);
        m_pu = 0; m_pd = 0;
        case (m_cur)
          0: begin
            if (up == 1 && dn == 0 && m_level < HI) m_level++;
            if (dn == 1 && up == 0 && m_level > LO) m_level--;
          end
          1: begin
            m_level = (m_level == HI) ? LO : m_level + 1;
            m_dir = 1;
          end
          2: begin
            if (m_dir == 1 && m_level == HI) m_dir = 0;
            if (m_dir == 0 && m_level == LO) m_dir = 1;
            m_level = (m_dir == 1) ? m_level + 1 : m_level - 1;
            if (m_level == HI) m_dir = 0;
            if (m_level == LO) m_dir = 1;
          end
          default: ;
        endcase
        begin
          int nd;
          nd = (m_cur == 3) ? 0 : m_level;
          m_strobe = (nd != m_duty) ? 1 : 0;
          m_duty = nd;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Continuous comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("model_duty", int'(duty_cycle), m_duty);
        check("model_strobe", int'(step_strobe), m_strobe);
        check("model_direction", int'(direction), m_dir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One step interval starting right after a tick; masks give per-cycle button pulses
  task automatic interval(input logic [15:0] up_mask, input logic [15:0] dn_mask);
    for (int i = 0; i < STEP; i++) begin
      btn_up   = up_mask[i];
      btn_down = dn_mask[i];
      @(negedge clk);
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 2'b00; btn_up = 1'b0; btn_down = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    check("reset_duty", int'(duty_cycle), 1);
    check("reset_strobe", int'(step_strobe), 0);
    check("reset_direction", int'(direction), 1);

    // Sawtooth: 2 after 16 cycles, 15 at cycle 224, wraps to 1 at 240
    mode = 2'b01; enable = 1'b1;
    cycles(16);
    check("saw_before_first_tick", int'(duty_cycle), 1);
    cycles(1);
    check("saw_first_step", int'(duty_cycle), 2);
    check("saw_first_strobe", int'(step_strobe), 1);
    cycles(1);
    check("saw_strobe_one_cycle", int'(step_strobe), 0);
    cycles(STEP * 13 - 1);
    check("saw_at_max", int'(duty_cycle), 15);
    cycles(STEP);
    check("saw_wrap", int'(duty_cycle), 1);
    check("saw_wrap_strobe", int'(step_strobe), 1);
    cycles(STEP * 6);
    check("saw_at_7", int'(duty_cycle), 7);

    // Asynchronous reset mid-ramp, checked without any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_duty", int'(duty_cycle), 1);
    check("async_reset_strobe", int'(step_strobe), 0);
    check("async_reset_direction", int'(direction), 1);
    enable = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

    // Triangle: up to 15 (direction drops), 14, down to 1, then 2
    mode = 2'b10; enable = 1'b1;
    cycles(17 + STEP * 13);
    check("tri_peak", int'(duty_cycle), 15);
    check("tri_peak_dir", int'(direction), 0);
    cycles(STEP);
    check("tri_after_peak", int'(duty_cycle), 14);
    check("tri_after_peak_dir", int'(direction), 0);
    cycles(STEP * 13);
    check("tri_floor", int'(duty_cycle), 1);
    check("tri_floor_dir", int'(direction), 1);
    cycles(STEP);
    check("tri_after_floor", int'(duty_cycle), 2);
    check("tri_after_floor_dir", int'(direction), 1);

    // Manual: enter with no buttons, climb to 5, then button semantics
    mode = 2'b00;
    interval(16'h0000, 16'h0000);
    check("manual_entry_hold", int'(duty_cycle), 2);
    check("manual_entry_no_strobe", int'(step_strobe), 0);
    for (int k = 0; k < 3; k++) interval(16'h0001, 16'h0000);
    check("manual_at_5", int'(duty_cycle), 5);
    interval(16'h0111, 16'h0000);
    check("manual_multi_up_one_step", int'(duty_cycle), 6);
    check("manual_multi_up_strobe", int'(step_strobe), 1);
    interval(16'h8000, 16'h8000);
    check("manual_both_hold", int'(duty_cycle), 6);
    check("manual_both_no_strobe", int'(step_strobe), 0);
    interval(16'h8000, 16'h0000);
    check("manual_tick_cycle_pulse", int'(duty_cycle), 7);
    for (int k = 0; k < 6; k++) interval(16'h0000, 16'h0004);
    check("manual_down_to_1", int'(duty_cycle), 1);
    interval(16'h0000, 16'h0004);
    check("manual_down_saturate", int'(duty_cycle), 1);
    check("manual_saturate_no_strobe", int'(step_strobe), 0);

    // Full: from level 9 go full-on, then back to sawtooth at 10
    mode = 2'b01;
    for (int k = 0; k < 8; k++) interval(16'h0000, 16'h0000);
    check("saw_to_9", int'(duty_cycle), 9);
    mode = 2'b11;
    interval(16'h0000, 16'h0000);
    check("full_duty", int'(duty_cycle), 0);
    check("full_strobe", int'(step_strobe), 1);
    interval(16'h0000, 16'h0000);
    check("full_hold_no_strobe", int'(step_strobe), 0);
    mode = 2'b01;
    interval(16'h0000, 16'h0000);
    check("full_exit_saw", int'(duty_cycle), 10);
    check("full_exit_strobe", int'(step_strobe), 1);

    // Enable low 100 cycles at 4, then 5 exactly STEP cycles after re-enable
    for (int k = 0; k < 9; k++) interval(16'h0000, 16'h0000);
    check("saw_to_4", int'(duty_cycle), 4);
    enable = 1'b0;
    cycles(100);
    check("disabled_hold", int'(duty_cycle), 4);
    check("disabled_no_strobe", int'(step_strobe), 0);
    enable = 1'b1;
    cycles(STEP);
    check("reenable_before_tick", int'(duty_cycle), 4);
    cycles(1);
    check("reenable_step", int'(duty_cycle), 5);
    check("reenable_strobe", int'(step_strobe), 1);

    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
